// File: rtl/pot_write_arbiter_if.sv
// Bus bundle between the pot write arbiter, its two requesters and the SPI pot writer.
// The master side is the requesters plus the writer; the slave side is the arbiter.
interface pot_write_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req0_done;

    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       req1_done;

    logic       pot_tx_en;
    logic [7:0] pot_data;
    logic       pot_tx_done;

    logic [7:0] wiper_q;
    logic       wiper_vld;
    logic       busy;
    logic       timeout_err;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, pot_tx_done,
        input  req0_ready, req0_done, req1_ready, req1_done,
        input  pot_tx_en, pot_data, wiper_q, wiper_vld, busy, timeout_err
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, pot_tx_done,
        output req0_ready, req0_done, req1_ready, req1_done,
        output pot_tx_en, pot_data, wiper_q, wiper_vld, busy, timeout_err
    );
endinterface

// File: rtl/pot_write_arbiter.sv
// Round-robin arbiter sharing one MCP41010 SPI pot writer between the host command path
// (req0) and the level/track loop (req1); one write in flight, shadow of the wiper code.
module pot_write_arbiter #(
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 255,
    parameter bit SKIP_SAME   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    pot_write_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        GAP     = 3'd4
    } state_t;

    localparam int               CNT_W      = 16;
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
    localparam state_t           AFTER_XFER = (GAP_CYC > 0) ? GAP : IDLE;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [7:0]       pot_data_q, pot_data_d;
    logic [7:0]       shadow_q, shadow_d;
    logic             shadow_vld_q, shadow_vld_d;
    logic             ready0_q, ready0_d;
    logic             ready1_q, ready1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             tx_en_q, tx_en_d;
    logic             tmo_err_q, tmo_err_d;
    logic             skip_pend_q, skip_pend_d;

    logic             win_vld;
    logic             win;
    logic [7:0]       win_data;

    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        gap_d        = gap_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        pot_data_d   = pot_data_q;
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
        ready0_d     = 1'b0;
        ready1_d     = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        tx_en_d      = 1'b0;
        tmo_err_d    = 1'b0;
        skip_pend_d  = 1'b0;
        win_vld      = 1'b0;
        win          = 1'b0;
        win_data     = 8'h00;

        // A skipped write completes one cycle after its ready pulse.
        if (skip_pend_q) begin
            if (owner_q) begin
                done1_d = 1'b1;
            end else begin
                done0_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                // While a ready pulse is out the requester still holds valid; do not regrant it.
                if (!ready0_q && !ready1_q) begin
                    if (bus.req0_valid && bus.req1_valid) begin
                        win_vld = 1'b1;
                        win     = ~last_grant_q;
                    end else if (bus.req0_valid) begin
                        win_vld = 1'b1;
                        win     = 1'b0;
                    end else if (bus.req1_valid) begin
                        win_vld = 1'b1;
                        win     = 1'b1;
                    end
                end
                win_data = win ? bus.req1_data : bus.req0_data;
                if (win_vld) begin
                    ready0_d     = ~win;
                    ready1_d     = win;
                    last_grant_d = win;
                    owner_d      = win;
                    pot_data_d   = win_data;
                    if (SKIP_SAME && shadow_vld_q && (win_data == shadow_q)) begin
                        skip_pend_d = 1'b1;
                    end else begin
                        state_d = LAUNCH;
                    end
                end
            end

            LAUNCH: begin
                tx_en_d = 1'b1;
                tmo_d   = '0;
                state_d = WAIT_LO;
            end

            WAIT_LO, WAIT_HI: begin
                tmo_d = tmo_q + CNT_W'(1);
                // Completion is checked before the timeout so a same-cycle tie counts as done.
                if ((state_q == WAIT_HI) && bus.pot_tx_done) begin
                    if (owner_q) begin
                        done1_d = 1'b1;
                    end else begin
                        done0_d = 1'b1;
                    end
                    shadow_d     = pot_data_q;
                    shadow_vld_d = 1'b1;
                    gap_d        = '0;
                    state_d      = AFTER_XFER;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_err_d    = 1'b1;
                    shadow_vld_d = 1'b0;
                    gap_d        = '0;
                    state_d      = AFTER_XFER;
                end else if ((state_q == WAIT_LO) && !bus.pot_tx_done) begin
                    state_d = WAIT_HI;
                end
            end

            GAP: begin
                gap_d = gap_q + CNT_W'(1);
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            tmo_q        <= '0;
            gap_q        <= '0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            pot_data_q   <= 8'h00;
            shadow_q     <= 8'h00;
            shadow_vld_q <= 1'b0;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            tx_en_q      <= 1'b0;
            tmo_err_q    <= 1'b0;
            skip_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            gap_q        <= gap_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            pot_data_q   <= pot_data_d;
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
            ready0_q     <= ready0_d;
            ready1_q     <= ready1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            tx_en_q      <= tx_en_d;
            tmo_err_q    <= tmo_err_d;
            skip_pend_q  <= skip_pend_d;
        end
    end

    assign bus.req0_ready  = ready0_q;
    assign bus.req1_ready  = ready1_q;
    assign bus.req0_done   = done0_q;
    assign bus.req1_done   = done1_q;
    assign bus.pot_tx_en   = tx_en_q;
    assign bus.pot_data    = pot_data_q;
    assign bus.wiper_q     = shadow_q;
    assign bus.wiper_vld   = shadow_vld_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.timeout_err = tmo_err_q;

endmodule

// File: tb/tb_pot_write_arbiter.sv
// Randomized bench for pot_write_arbiter: a transaction-level model of the arbitration,
// shadow and timing rules, plus a behavioural MCP41010 writer.
module tb_pot_write_arbiter;
    localparam int GAP_CYC     = 4;
    localparam int TIMEOUT_CYC = 60;
    localparam int WAIT_LIM    = 400;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pot_write_arbiter_if bus();

    pot_write_arbiter #(
        .GAP_CYC    (GAP_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .SKIP_SAME  (1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Cycle index, bumped on each rising edge.
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural writer: tx_done idles high, drops after a launch, rises when the word is out.
    int   wph = 0;
    int   wcnt = 0;
    bit   wr_hang_cur = 0;
    bit   hang_force = 0;
    bit   hang_rand = 0;
    bit   wr_slow = 0;
    int   wr_rise_cyc = -100;

    initial begin
        bus.pot_tx_done = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                bus.pot_tx_done = 1'b1;
                wph = 0;
                wr_rise_cyc = -100;
            end else if (bus.pot_tx_en === 1'b1) begin
                wph = 1;
                wcnt = wr_slow ? 6 : int'($urandom_range(0, 2));
                wr_hang_cur = hang_force || (hang_rand && ($urandom_range(0, 11) == 0));
                wr_rise_cyc = -100;
            end else if (wph == 1) begin
                if (wcnt == 0) begin
                    bus.pot_tx_done = 1'b0;
                    wph = 2;
                    wcnt = wr_slow ? 12 : int'($urandom_range(2, 20));
                end else begin
                    wcnt--;
                end
            end else if (wph == 2 && !wr_hang_cur) begin
                if (wcnt == 0) begin
                    bus.pot_tx_done = 1'b1;
                    wph = 0;
                    wr_rise_cyc = cyc;
                end else begin
                    wcnt--;
                end
            end
        end
    end

    // Reference model: one open transaction, shadow wiper, last winner, last completion time.
    bit         txn_open = 0;
    int         t_owner = 0;
    logic [7:0] t_data = 8'h00;
    bit         t_skip = 0;
    bit         t_launched = 0;
    int         ready_cyc = 0;
    int         launch_cyc = 0;
    int         end_cyc = 0;
    bit         have_end = 0;
    logic [7:0] m_wiper = 8'h00;
    bit         m_vld = 0;
    int         m_last = 1;
    int         grants [2] = '{0, 0};
    int         dones = 0;
    int         tmos = 0;
    int         launches = 0;
    logic       pv0 = 1'b0, pv1 = 1'b0;
    logic [7:0] pd0 = 8'h00, pd1 = 8'h00;

    initial begin
        int w;
        int exp_w;
        forever begin
            @(negedge clk);
            if (!rst) begin
                txn_open = 0;
                m_vld    = 0;
                m_wiper  = 8'h00;
                m_last   = 1;
                have_end = 0;
            end else begin
                if (bus.req0_done || bus.req1_done) begin
                    w = bus.req1_done ? 1 : 0;
                    check_eq("done_onehot", {30'd0, bus.req0_done, bus.req1_done}, (w == 1) ? 1 : 2);
                    check_eq("done_in_txn", txn_open, 1);
                    check_eq("done_owner", w, t_owner);
                    check_eq("done_not_with_tmo", bus.timeout_err, 0);
                    if (t_skip) begin
                        check_eq("skip_done_latency", cyc - ready_cyc, 1);
                    end else begin
                        check_eq("done_after_launch", t_launched, 1);
                        check_eq("done_after_rise", cyc - wr_rise_cyc, 1);
                        have_end = 1;
                        end_cyc  = cyc;
                    end
                    m_wiper  = t_data;
                    m_vld    = 1;
                    txn_open = 0;
                    dones++;
                end
                if (bus.timeout_err) begin
                    check_eq("tmo_in_txn", txn_open && t_launched, 1);
                    check_eq("tmo_latency", cyc - launch_cyc, TIMEOUT_CYC);
                    m_vld    = 0;
                    txn_open = 0;
                    have_end = 1;
                    end_cyc  = cyc;
                    tmos++;
                end
                if (bus.req0_ready || bus.req1_ready) begin
                    w = bus.req1_ready ? 1 : 0;
                    check_eq("ready_onehot", {30'd0, bus.req0_ready, bus.req1_ready}, (w == 1) ? 1 : 2);
                    check_eq("ready_one_in_flight", txn_open, 0);
                    check_eq("ready_had_request", (w == 1) ? pv1 : pv0, 1);
                    exp_w = (pv0 && pv1) ? (1 - m_last) : (pv1 ? 1 : 0);
                    check_eq("winner", w, exp_w);
                    t_data = (w == 1) ? pd1 : pd0;
                    check_eq("grant_pot_data", bus.pot_data, t_data);
                    txn_open   = 1;
                    t_owner    = w;
                    t_skip     = m_vld && (t_data == m_wiper);
                    t_launched = 0;
                    ready_cyc  = cyc;
                    m_last     = w;
                    grants[w]++;
                end
                if (bus.pot_tx_en) begin
                    check_eq("launch_expected", txn_open && !t_skip && !t_launched, 1);
                    check_eq("launch_latency", cyc - ready_cyc, 1);
                    check_eq("launch_data", bus.pot_data, t_data);
                    if (have_end) begin
                        check_eq("launch_gap_ok", (cyc - end_cyc) >= (GAP_CYC + 1), 1);
                    end
                    t_launched = 1;
                    launch_cyc = cyc;
                    launches++;
                end
                if (txn_open && (cyc - ready_cyc) > (TIMEOUT_CYC + 20)) begin
                    check_eq("txn_age", cyc - ready_cyc, TIMEOUT_CYC + 20);
                    txn_open = 0;
                end
                check_eq("wiper_vld", bus.wiper_vld, m_vld);
                if (m_vld) begin
                    check_eq("wiper_q", bus.wiper_q, m_wiper);
                end
            end
            pv0 = bus.req0_valid;
            pv1 = bus.req1_valid;
            pd0 = bus.req0_data;
            pd1 = bus.req1_data;
        end
    end

    task automatic set_req(input int n, input logic v, input logic [7:0] d);
        if (n == 1) begin
            bus.req1_valid = v;
            bus.req1_data  = d;
        end else begin
            bus.req0_valid = v;
            bus.req0_data  = d;
        end
    endtask

    task automatic req(input int n, input logic [7:0] d);
        int   k;
        logic got;
        @(posedge clk);
        #1;
        set_req(n, 1'b1, d);
        k   = 0;
        got = 1'b0;
        do begin
            @(negedge clk);
            k++;
            got = (n == 1) ? bus.req1_ready : bus.req0_ready;
        end while (k < WAIT_LIM && !got);
        check_eq("req_accepted", got, 1);
        @(posedge clk);
        #1;
        set_req(n, 1'b0, d);
    endtask

    task automatic wait_quiet();
        int k;
        bit quiet;
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
            quiet = !txn_open && !bus.busy;
        end while (k < WAIT_LIM && !quiet);
        check_eq("quiet_reached", quiet, 1);
    endtask

    task automatic rand_req(input int n);
        logic [7:0] d;
        int         sel;
        repeat ($urandom_range(0, 12)) @(posedge clk);
        sel = int'($urandom_range(0, 3));
        d = (sel == 0) ? m_wiper : (sel == 1) ? 8'h80 : 8'($urandom);
        if ($urandom_range(0, 9) == 0) begin
            @(posedge clk);
            #1;
            set_req(n, 1'b1, d);
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
            set_req(n, 1'b0, d);
        end else begin
            req(n, d);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_pot_data"}, bus.pot_data, 0);
        check_eq({pfx, "_wiper_q"}, bus.wiper_q, 0);
        check_eq({pfx, "_wiper_vld"}, bus.wiper_vld, 0);
        check_eq({pfx, "_busy"}, bus.busy, 0);
        check_eq({pfx, "_req0_ready"}, bus.req0_ready, 0);
        check_eq({pfx, "_req1_ready"}, bus.req1_ready, 0);
        check_eq({pfx, "_req0_done"}, bus.req0_done, 0);
        check_eq({pfx, "_req1_done"}, bus.req1_done, 0);
        check_eq({pfx, "_pot_tx_en"}, bus.pot_tx_en, 0);
        check_eq({pfx, "_timeout_err"}, bus.timeout_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_watchdog: simulation still running at t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         l0, d0, t0, gs, k;
        logic       got;
        logic [7:0] d6;
        bus.req0_valid = 1'b0;
        bus.req0_data  = 8'h00;
        bus.req1_valid = 1'b0;
        bus.req1_data  = 8'h00;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Single host write; writer still shows tx_done=1 for a while after launch.
        wr_slow = 1;
        l0 = launches;
        d0 = dones;
        req(0, 8'h80);
        wait_quiet();
        check_eq("t1_launches", launches - l0, 1);
        check_eq("t1_dones", dones - d0, 1);
        check_eq("t1_wiper_q", bus.wiper_q, 8'h80);
        check_eq("t1_wiper_vld", bus.wiper_vld, 1);
        wr_slow = 0;

        // Same code from the loop is absorbed by the shadow.
        l0 = launches;
        d0 = dones;
        req(1, 8'h80);
        wait_quiet();
        check_eq("t3_no_launch", launches - l0, 0);
        check_eq("t3_done", dones - d0, 1);

        // Both requesters hammering: grants must alternate.
        gs = grants[0] + grants[1];
        l0 = grants[0];
        @(posedge clk);
        #1;
        set_req(0, 1'b1, 8'h10);
        set_req(1, 1'b1, 8'h20);
        for (int i = 0; i < 3000 && (grants[0] + grants[1] - gs) < 8; i++) @(negedge clk);
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 8'h10);
        set_req(1, 1'b0, 8'h20);
        wait_quiet();
        check_eq("t2_grant_count", grants[0] + grants[1] - gs, 8);
        check_eq("t2_grants_req0", grants[0] - l0, 4);
        check_eq("t2_wiper_q", bus.wiper_q, 8'h20);

        // Writer stuck low: abort on timeout, then recover.
        hang_force = 1;
        d0 = dones;
        t0 = tmos;
        req(0, 8'h55);
        wait_quiet();
        check_eq("t4_timeouts", tmos - t0, 1);
        check_eq("t4_no_done", dones - d0, 0);
        check_eq("t4_wiper_vld", bus.wiper_vld, 0);
        hang_force = 0;
        req(1, 8'h66);
        wait_quiet();
        check_eq("t4_recover_done", dones - d0, 1);
        check_eq("t4_recover_wiper", bus.wiper_q, 8'h66);
        check_eq("t4_recover_vld", bus.wiper_vld, 1);

        // Randomized traffic from both sides with occasional hangs and withdrawn requests.
        hang_rand = 1;
        gs = grants[0] + grants[1];
        d0 = dones;
        t0 = tmos;
        fork
            begin
                for (int i = 0; i < 25; i++) rand_req(0);
            end
            begin
                for (int j = 0; j < 25; j++) rand_req(1);
            end
        join
        hang_rand = 0;
        wait_quiet();
        check_eq("rand_accounting", (dones - d0) + (tmos - t0), grants[0] + grants[1] - gs);

        // Reset in the middle of a transfer with req1 pending.
        wr_slow = 1;
        d6 = m_wiper ^ 8'h5A;
        req(0, d6);
        @(posedge clk);
        #1;
        set_req(1, 1'b1, 8'h44);
        k = 0;
        while (k < WAIT_LIM && bus.pot_tx_done !== 1'b0) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("t6_writer_low", bus.pot_tx_done, 0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("t6_async");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        k   = 0;
        got = 1'b0;
        do begin
            @(negedge clk);
            k++;
            got = bus.req1_ready;
        end while (k < WAIT_LIM && !got);
        check_eq("t6_req1_accepted", got, 1);
        @(posedge clk);
        #1;
        set_req(1, 1'b0, 8'h44);
        wait_quiet();
        check_eq("t6_wiper_q", bus.wiper_q, 8'h44);
        check_eq("t6_wiper_vld", bus.wiper_vld, 1);
        wr_slow = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
